// File: rtl/data_mem_pipe.sv
// rtl/data_mem_pipe.sv - pipelined data memory with credit-limited in-order response FIFO (option: DMEM_MISALIGN_ERR_EN)
module data_mem_pipe #(
    parameter int DMEM_WORDS = 1024,
    parameter int RD_LATENCY = 1,
    parameter int RSP_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_wr_i,
    input  logic [31:0] req_wr_data_i,
    input  logic        req_zero_extnd_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rd_data_o,
    output logic        rsp_wr_o,
    output logic        rsp_err_o
);

    localparam int IW = $clog2(DMEM_WORDS);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
    localparam logic [29:0]   WORDS_C = 30'(DMEM_WORDS);

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Storage array: deliberately not reset so it can map onto RAM.
    logic [31:0] mem [DMEM_WORDS];

    logic          accept;
    logic          pop;
    logic          push;
    logic [IW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic          range_err;
    logic          size_err;
    logic          align_err;
    logic          req_err;
    logic          mem_we;
    logic [3:0]    wr_be;
    logic [31:0]   wr_word;
    logic [7:0]    lane_byte;
    logic [15:0]   lane_half;
    logic [31:0]   ld_data;
    logic [31:0]   pipe_in_data;

    logic [CW-1:0] outstanding_q, outstanding_d;

    logic [RD_LATENCY-1:0] pv_q, pv_d;
    logic [RD_LATENCY-1:0] pw_q, pw_d;
    logic [RD_LATENCY-1:0] pe_q, pe_d;
    logic [31:0]           pd_q [RD_LATENCY];
    logic [31:0]           pd_d [RD_LATENCY];

    logic [31:0]          fd_q [RSP_DEPTH];
    logic [31:0]          fd_d [RSP_DEPTH];
    logic [RSP_DEPTH-1:0] fw_q, fw_d;
    logic [RSP_DEPTH-1:0] fe_q, fe_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    // Credit limit comes from registered state only, so no path from rsp_ready_i.
    assign req_ready_o = (outstanding_q < DEPTH_C);
    assign accept      = req_valid_i && req_ready_o;

    assign rsp_valid_o   = (cnt_q != '0);
    assign rsp_rd_data_o = rsp_valid_o ? fd_q[rd_ptr_q] : 32'h0;
    assign rsp_wr_o      = rsp_valid_o & fw_q[rd_ptr_q];
    assign rsp_err_o     = rsp_valid_o & fe_q[rd_ptr_q];
    assign pop           = rsp_valid_o && rsp_ready_i;
    assign push          = pv_q[RD_LATENCY-1];

    // Request decode: fault checks, store byte enables and formatted load data.
    always_comb begin
        word_idx  = req_addr_i[IW+1:2];
        rd_word   = mem[word_idx];
        range_err = (req_addr_i[31:2] >= WORDS_C);
        size_err  = (req_size_i == SZ_ILLEGAL);
`ifdef DMEM_MISALIGN_ERR_EN
        align_err = ((req_size_i == SZ_HALF) && req_addr_i[0]) ||
                    ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));
`else
        align_err = 1'b0;
`endif
        req_err = range_err || size_err || align_err;
        mem_we  = accept && req_wr_i && !req_err;

        wr_be   = 4'b0000;
        wr_word = req_wr_data_i;
        case (req_size_i)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << req_addr_i[1:0];
                wr_word = {4{req_wr_data_i[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{req_wr_data_i[15:0]}};
            end
            SZ_WORD: wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase

        case (req_addr_i[1:0])
            2'b00:   lane_byte = rd_word[7:0];
            2'b01:   lane_byte = rd_word[15:8];
            2'b10:   lane_byte = rd_word[23:16];
            default: lane_byte = rd_word[31:24];
        endcase
        lane_half = req_addr_i[1] ? rd_word[31:16] : rd_word[15:0];

        case (req_size_i)
            SZ_BYTE: ld_data = {{24{~req_zero_extnd_i & lane_byte[7]}}, lane_byte};
            SZ_HALF: ld_data = {{16{~req_zero_extnd_i & lane_half[15]}}, lane_half};
            SZ_WORD: ld_data = rd_word;
            default: ld_data = 32'h0;
        endcase

        pipe_in_data = (req_wr_i || req_err) ? 32'h0 : ld_data;
    end

    // Store commit at the accept edge; only the enabled byte lanes change.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

    // Latency pipe: a fixed-length shift of response tokens, never stalls.
    always_comb begin
        pv_d    = '0;
        pw_d    = '0;
        pe_d    = '0;
        pd_d    = pd_q;
        pv_d[0] = accept;
        pw_d[0] = req_wr_i;
        pe_d[0] = req_err;
        pd_d[0] = pipe_in_data;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pw_d[i] = pw_q[i-1];
            pe_d[i] = pe_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
    end

    // Response FIFO: the credit limit guarantees a push never meets a full FIFO.
    always_comb begin
        fd_d     = fd_q;
        fw_d     = fw_q;
        fe_d     = fe_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            fd_d[wr_ptr_q] = pd_q[RD_LATENCY-1];
            fw_d[wr_ptr_q] = pw_q[RD_LATENCY-1];
            fe_d[wr_ptr_q] = pe_q[RD_LATENCY-1];
            wr_ptr_d       = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Outstanding credits: requests in the pipe plus entries waiting in the FIFO.
    always_comb begin
        case ({accept, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Control and response state; reset drops everything in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding_q <= '0;
            pv_q          <= '0;
            pw_q          <= '0;
            pe_q          <= '0;
            for (int i = 0; i < RD_LATENCY; i++) pd_q[i] <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) fd_q[i] <= '0;
            fw_q          <= '0;
            fe_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            pv_q          <= pv_d;
            pw_q          <= pw_d;
            pe_q          <= pe_d;
            pd_q          <= pd_d;
            fd_q          <= fd_d;
            fw_q          <= fw_d;
            fe_q          <= fe_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

endmodule

// File: tb/tb_data_mem_pipe.sv
// tb/tb_data_mem_pipe.sv - randomized self-checking bench for data_mem_pipe against a byte-level model
module tb_data_mem_pipe;

    localparam int DW  = 1024;
    localparam int LAT = 1;
    localparam int DEP = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_addr_i;
    logic [1:0]  req_size_i;
    logic        req_wr_i;
    logic [31:0] req_wr_data_i;
    logic        req_zero_extnd_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rd_data_o;
    logic        rsp_wr_o;
    logic        rsp_err_o;

    data_mem_pipe #(.DMEM_WORDS(DW), .RD_LATENCY(LAT), .RSP_DEPTH(DEP)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_size_i       (req_size_i),
        .req_wr_i         (req_wr_i),
        .req_wr_data_i    (req_wr_data_i),
        .req_zero_extnd_i (req_zero_extnd_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_ready_i      (rsp_ready_i),
        .rsp_rd_data_o    (rsp_rd_data_o),
        .rsp_wr_o         (rsp_wr_o),
        .rsp_err_o        (rsp_err_o)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        logic [31:0] data;
        logic        wr;
        logic        err;
        bit          dk;
        int          vis;
        bit          len;
        logic [31:0] lit;
        logic        lerr;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mb [DW*4];
    bit         kn [DW*4];
    int         n_pass = 0;
    int         n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (edge %0d)", nm, act, exp, edges);
    endtask

    // Reference: memory as a flat byte array, sizes as byte counts.
    task automatic model_req(input logic [31:0] a, input logic [1:0] sz, input logic wr,
                             input logic [31:0] wd, input logic zx, output exp_t e);
        int n;
        int b;
        logic [31:0] v;
        bit err;
        err = ({2'b00, a[31:2]} >= 32'(DW)) || (sz == 2'b11);
`ifdef DMEM_MISALIGN_ERR_EN
        if (sz == 2'b01 && a[0]) err = 1;
        if (sz == 2'b10 && a[1:0] != 2'b00) err = 1;
`endif
        e.wr = wr; e.err = err; e.data = 32'h0; e.dk = 1; e.len = 0; e.lit = 0; e.lerr = 0;
        if (!err) begin
            n = 1 << sz;
            b = int'({2'b00, a[31:2]}) * 4 + ((n == 1) ? int'(a[1:0]) : (n == 2) ? 2 * int'(a[1]) : 0);
            if (wr) begin
                for (int i = 0; i < n; i++) begin
                    mb[b+i] = wd[8*i +: 8];
                    kn[b+i] = 1;
                end
            end else begin
                v = 32'h0;
                for (int i = 0; i < n; i++) begin
                    v[8*i +: 8] = mb[b+i];
                    if (!kn[b+i]) e.dk = 0;
                end
                if (!zx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                e.data = v;
            end
        end
    endtask

    // One cycle: compare outputs, drive the next request, advance the model, move to next negedge.
    task automatic step(input logic v, input logic [31:0] a, input logic [1:0] sz, input logic wr,
                        input logic [31:0] wd, input logic zx, input logic rr,
                        input logic len, input logic [31:0] lit, input logic lerr,
                        output logic acc, output logic dacc);
        exp_t e;
        logic ev;
        ev = (q.size() > 0) && (q[0].vis <= edges);
        chk("req_ready_o", {31'b0, req_ready_o}, {31'b0, (q.size() < DEP)});
        chk("rsp_valid_o", {31'b0, rsp_valid_o}, {31'b0, ev});
        if (ev) begin
            if (q[0].dk) chk("rsp_rd_data_o", rsp_rd_data_o, q[0].data);
            chk("rsp_wr_o", {31'b0, rsp_wr_o}, {31'b0, q[0].wr});
            chk("rsp_err_o", {31'b0, rsp_err_o}, {31'b0, q[0].err});
            if (q[0].len) begin
                chk("literal_data", rsp_rd_data_o, q[0].lit);
                chk("literal_err", {31'b0, rsp_err_o}, {31'b0, q[0].lerr});
            end
        end
        req_valid_i = v; req_addr_i = a; req_size_i = sz; req_wr_i = wr;
        req_wr_data_i = wd; req_zero_extnd_i = zx; rsp_ready_i = rr;
        acc  = v && (q.size() < DEP);
        dacc = v && req_ready_o;
        if (ev && rr) void'(q.pop_front());
        if (acc) begin
            model_req(a, sz, wr, wd, zx, e);
            e.vis = edges + 1 + LAT; e.len = len; e.lit = lit; e.lerr = lerr;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic rr);
        logic acc, dacc;
        step(0, 32'h0, 2'b00, 0, 32'h0, 0, rr, 0, 32'h0, 0, acc, dacc);
    endtask

    task automatic rq(input logic [31:0] a, input logic [1:0] sz, input logic wr, input logic [31:0] wd,
                      input logic zx, input logic len, input logic [31:0] lit, input logic lerr);
        logic acc, dacc;
        int tries;
        acc = 0; tries = 0;
        while (!acc && tries < 50) begin
            step(1, a, sz, wr, wd, zx, 1, len, lit, lerr, acc, dacc);
            tries++;
        end
        if (!acc) begin
            n_total++;
            $display("FAIL rq_timeout: request @%h not accepted", a);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() > 0 && t < 100) begin idle(1); t++; end
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d responses left", q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        logic        acc, dacc, v, wr, zx, rr;
        logic [31:0] a, wd;
        logic [1:0]  sz;
        int          nacc, r;

        reset_n = 0; req_valid_i = 0; req_addr_i = 0; req_size_i = 0; req_wr_i = 0;
        req_wr_data_i = 0; req_zero_extnd_i = 0; rsp_ready_i = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", {31'b0, req_ready_o}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("reset_rd_data", rsp_rd_data_o, 32'h0);
        chk("reset_wr", {31'b0, rsp_wr_o}, 32'd0);
        chk("reset_err", {31'b0, rsp_err_o}, 32'd0);
        reset_n = 1;
        @(negedge clk);

        // Prefill the low window and the top boundary words.
        for (int w = 0; w < 16; w++) rq(w * 4, 2'b10, 1, $urandom, 0, 0, 0, 0);
        for (int w = DW - 4; w < DW; w++) rq(w * 4, 2'b10, 1, $urandom, 0, 0, 0, 0);

        // Store/load round trip.
        rq(32'h10, 2'b10, 1, 32'hDEADBEEF, 0, 0, 0, 0);
        rq(32'h13, 2'b00, 0, 0, 0, 1, 32'hFFFF_FFDE, 0);
        rq(32'h13, 2'b00, 0, 0, 1, 1, 32'h0000_00DE, 0);
        // Half-word store merge.
        rq(32'h20, 2'b10, 1, 32'h12345678, 0, 0, 0, 0);
        rq(32'h22, 2'b01, 1, 32'h0000_8001, 0, 0, 0, 0);
        rq(32'h22, 2'b01, 0, 0, 0, 1, 32'hFFFF_8001, 0);
        rq(32'h20, 2'b10, 0, 0, 0, 1, 32'h8001_5678, 0);
        // Errors.
        rq(DW * 4, 2'b10, 0, 0, 0, 1, 32'h0, 1);
        rq(32'h0, 2'b11, 0, 0, 0, 1, 32'h0, 1);
        rq(32'h4, 2'b10, 1, 32'h11111111, 0, 0, 0, 0);
`ifdef DMEM_MISALIGN_ERR_EN
        rq(32'h6, 2'b10, 1, 32'hAABBCCDD, 0, 1, 32'h0, 1);
        rq(32'h4, 2'b10, 0, 0, 0, 1, 32'h11111111, 0);
`else
        rq(32'h6, 2'b10, 1, 32'hAABBCCDD, 0, 1, 32'h0, 0);
        rq(32'h4, 2'b10, 0, 0, 0, 1, 32'hAABBCCDD, 0);
`endif
        drain();

        // Back-pressure: six loads offered with the consumer stalled.
        nacc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1, i * 4, 2'b10, 0, 0, 0, 0, 0, 0, 0, acc, dacc);
            nacc += int'(dacc);
        end
        chk("bp_accepted", nacc, 32'd4);
        chk("bp_ready_low", {31'b0, req_ready_o}, 32'd0);
        for (int t = 0; t < 40 && nacc < 6; t++) begin
            step(1, nacc * 4, 2'b10, 0, 0, 0, 1, 0, 0, 0, acc, dacc);
            nacc += int'(acc);
        end
        drain();
        chk("bp_ready_recovered", {31'b0, req_ready_o}, 32'd1);

        // Streaming: 16 back-to-back loads, no ready bubble.
        nacc = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, i * 4, 2'b10, 0, 0, 0, 1, 0, 0, 0, acc, dacc);
            nacc += int'(dacc);
        end
        chk("stream_accepted", nacc, 32'd16);
        drain();

        // Random traffic with random consumer stalls.
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0)      a = DW * 4 + $urandom_range(0, 4095);
            else if (r == 1) a = $urandom | 32'h8000_0000;
            else if (r < 15) a = $urandom_range(0, 63);
            else             a = DW * 4 - 1 - $urandom_range(0, 15);
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            v  = ($urandom_range(0, 3) != 0);
            wr = $urandom_range(0, 1) == 1;
            zx = $urandom_range(0, 1) == 1;
            rr = ($urandom_range(0, 9) < 7);
            wd = $urandom;
            step(v, a, sz, wr, wd, zx, rr, 0, 0, 0, acc, dacc);
        end
        drain();

        // Reset with three responses queued; committed stores survive.
        rq(32'h40, 2'b10, 1, 32'hCAFEF00D, 0, 0, 0, 0);
        drain();
        for (int i = 0; i < 3; i++) step(1, i * 4, 2'b10, 0, 0, 0, 0, 0, 0, 0, acc, dacc);
        for (int i = 0; i < LAT + 2; i++) idle(0);
        chk("pre_reset_valid", {31'b0, rsp_valid_o}, 32'd1);
        req_valid_i = 0;
        reset_n = 0;
        #1;
        chk("mid_reset_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("mid_reset_ready", {31'b0, req_ready_o}, 32'd1);
        chk("mid_reset_data", rsp_rd_data_o, 32'h0);
        q.delete();
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        rq(32'h40, 2'b10, 0, 0, 0, 1, 32'hCAFEF00D, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_pipe.md
# data_mem_pipe

Pipelined, parametrised data memory with a valid/ready request channel and a buffered valid/ready response channel. It replaces the single-cycle data memory in the pipelined core's MEM stage. It has configurable read latency, credit-based back-pressure, and error responses for out-of-range, illegal-size and (optionally) misaligned accesses. Every accepted request, read or write, returns exactly one response, in order.

## Interface
- `DMEM_WORDS`, 1024: number of 32-bit words; power of 2, ≥ 4.
- `RD_LATENCY`, 1: edges from request accept to the response entering the response FIFO; legal range 1..4.
- `RSP_DEPTH`, 4: response FIFO entries and the outstanding-request limit; power of 2, ≥ `RD_LATENCY+2`.

- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: request valid.
- `req_ready_o` out 1: request accepted this cycle if `req_valid_i` is also high.
- `req_addr_i` in 32: byte address.
- `req_size_i` in 2: access size, using `riscv_pkg` encodings `BYTE`=00, `HALF_WORD`=01, `WORD`=10; 11 is illegal.
- `req_wr_i` in 1: 1 = store, 0 = load.
- `req_wr_data_i` in 32: store data, right-aligned.
- `req_zero_extnd_i` in 1: load zero-extends when 1, sign-extends when 0.
- `rsp_valid_o` out 1: response valid.
- `rsp_ready_i` in 1: consumer accepts the response.
- `rsp_rd_data_o` out 32: formatted load data; 0 for stores and errors.
- `rsp_wr_o` out 1: response belongs to a store.
- `rsp_err_o` out 1: access faulted; no memory side effect.

## Operation
- **Accept:** the request is accepted on an edge where `req_valid_i && req_ready_o`.
- **Credit counter:** `outstanding` (width `$clog2(RSP_DEPTH)+1`) counts requests in the latency pipe plus entries in the FIFO.
  - +1 on accept, −1 on pop (`rsp_valid_o && rsp_ready_i`); unchanged when both happen on the same edge.
  - `req_ready_o = (outstanding < RSP_DEPTH)`, registered-state only, with no combinational path from `rsp_ready_i`.
- **Error checks:** evaluated at accept.
  - `req_addr_i[31:2] >= DMEM_WORDS` → `err`.
  - `req_size_i == 2'b11` → `err`.
  - Misalignment → `err`, only when the macro is enabled.
- **Store (no error):** commits to the array at the accept edge.
  - `BYTE`: lane `addr[1:0]` is written from `wr_data[7:0]`.
  - `HALF_WORD`: the half selected by `addr[1]` is written from `wr_data[15:0]`.
  - `WORD`: the full word is written.
- **Load (no error):** the word is read at the accept edge, so it reflects all previously accepted stores, including the store accepted on the previous edge.
  - The lane is selected by `addr[1:0]` (`BYTE`) or `addr[1]` (`HALF_WORD`).
  - Zero- or sign-extension is applied before the result enters the pipe.
- **Errored request:** no array write; the response carries `rd_data=0`, `err=1`, and `wr=req_wr_i`.
- **Latency pipe:** `RD_LATENCY` stages, each holding {valid, data, wr, err}. A stage-`RD_LATENCY` valid pushes into the FIFO. The FIFO cannot overflow, by the credit rule.
- **FIFO outputs:** the FIFO head drives `rsp_*`. Read/write pointers wrap modulo `RSP_DEPTH`. A simultaneous push and pop on a full or empty FIFO is legal.
- **Response hold:** `rsp_*` stays stable while `rsp_valid_o && !rsp_ready_i`.
- **Array reset:** the array is not reset, so it can map to RAM; its contents are undefined after power-up.

## Timing
- **Reset values:** `req_ready_o=1`, `rsp_valid_o=0`, `rsp_rd_data_o=0`, `rsp_wr_o=0`, `rsp_err_o=0`; pipe and FIFO empty; `outstanding=0`.
- **Response latency:** a request accepted at edge N with an empty FIFO gives `rsp_valid_o` high in the cycle after edge N+`RD_LATENCY`.
- **Throughput:** one request per cycle, sustained, while `rsp_ready_i=1`.
- **Back-pressure:** with `rsp_ready_i=0`, `req_ready_o` falls once `RSP_DEPTH` requests are outstanding. It rises in the cycle after the first pop.
- **Reset mid-operation:** all in-flight and queued responses are dropped. Stores already committed remain in the array.

## Configuration
- `DMEM_MISALIGN_ERR_EN` defined:
  - A `HALF_WORD` access with `addr[0]=1` is an error response.
  - A `WORD` access with `addr[1:0]≠0` is an error response.
- `DMEM_MISALIGN_ERR_EN` undefined:
  - No misalignment errors are raised.
  - `HALF_WORD` ignores `addr[0]`.
  - `WORD` ignores `addr[1:0]`.

## Test plan
- **Store/load round trip:** `RD_LATENCY=1`; store word `0xDEADBEEF` @`0x10`, then LB @`0x13` with sign-extension → `rsp_rd_data_o=0xFFFFFFDE` one cycle after accept; LBU → `0x000000DE`.
- **Half-word store:** SH `0x8001` @`0x22`, then LH @`0x22` → `0xFFFF8001`; LW @`0x20` → upper half `0x8001`, lower half unchanged.
- **Back-pressure:** `RSP_DEPTH=4`, `rsp_ready_i=0`, issue 6 loads → exactly 4 accepted and `req_ready_o=0`. Raise `rsp_ready_i` → 4 responses in order, the remaining 2 accepted, `outstanding` returns to 0.
- **Streaming:** `RD_LATENCY=3`, `RSP_DEPTH=8`, 16 back-to-back loads with `rsp_ready_i=1` → 16 consecutive responses, first one 3 edges after the first accept, no `req_ready_o` bubble.
- **Errors:** LW @ `DMEM_WORDS*4` → `err=1`, data 0. `req_size_i=11` → `err=1`. Macro on: SW @`0x6` → `err=1` and word @`0x4` unchanged. Macro off: the same SW writes the word @`0x4`.
- **Reset mid-operation:** assert `reset_n` low with 3 responses queued → `rsp_valid_o=0` immediately. After reset, a load of a previously committed address returns the stored value.
